temporal_encoder_b_t: RTL
=========================

// Module: temporal_encoder_b_t
// PURPOSE
//   Binary-to-temporal encoder: the producer for temporal-input blocks such as the
//   temporal-select muxes. Accepts a vector of binary arrival times, then emits one
//   rising-edge temporal pulse per channel at that time within the next gamma cycle.
//   Owns the free-running gamma counter and exports the phase so downstream blocks align.
// PARAMETERS
//   GAMMA_CYCLE_WIDTH  16  cycles per gamma cycle; power of 2, >=2
//   PULSE_WIDTH         8  pulse length in aclk cycles; 1..GAMMA_CYCLE_WIDTH
//   NUM_CHANNELS        4  independent temporal output lines
//   (derived) VW = $clog2(GAMMA_CYCLE_WIDTH); LAST = GAMMA_CYCLE_WIDTH-1
// PORTS
//   aclk         in   1                clock
//   grst         in   1                synchronous, active-high reset
//   in_valid     in   1                input vector valid
//   in_ready     out  1                encoder can accept a vector this cycle
//   in_values    in   NUM_CHANNELS*VW  per-channel arrival time; channel c at [c*VW +: VW]
//   in_silent    in   NUM_CHANNELS     1 = channel emits no spike this gamma cycle
//   gamma_phase  out  VW               current phase, 0..LAST, registered
//   gamma_start  out  1                high when gamma_phase == 0, registered
//   out          out  NUM_CHANNELS     temporal pulses, registered
// BEHAVIOUR
// - Reset (sync, grst high at posedge): phase 0, gamma_start 1, out 0, shadow empty,
//   active vector all-silent. in_ready is 1 in the first cycle after reset.
//   Reset mid-gamma or mid-pulse: all state returns to reset values at that edge.
//   Held or pending vectors are discarded. No partial pulse survives.
// - Counter: phase increments each cycle and wraps LAST -> 0 with no stall. It runs
//   regardless of the handshake.
// - Handshake: a transfer occurs when in_valid && in_ready at a posedge.
//   in_ready = !shadow_full || (phase == LAST). The producer must hold in_values and
//   in_silent stable while in_valid && !in_ready.
// - Buffering: two registers, shadow (1 entry) and active.
//   - Transfer at phase != LAST: the vector is written to shadow; shadow_full <= 1.
//   - At the edge leaving phase LAST:
//       shadow_full: active <= shadow. Shadow <= the transferring vector if one is
//         present (stays full), else shadow empties.
//       !shadow_full with transfer: active <= the vector directly; shadow stays empty.
//       neither: active <= all-silent, so the next gamma cycle is quiet.
//   - Result: a vector accepted during gamma k is emitted in gamma k+1, with one
//     vector of slack.
// - Pulse rule, per channel c in the gamma cycle using active:
//   - out[c] == 1 iff !silent_c && phase >= v_c && phase < v_c + PULSE_WIDTH.
//   - The comparison is in VW+1 bits. Pulses are clipped at LAST and never wrap.
//   - out and gamma_phase update on the same edge, so this relation holds
//     cycle-for-cycle on the ports.
// - Simultaneity: all channels are independent. Equal v_c values give pulses that
//   are identical on the same cycles.
// - v_c = 0 is a valid value: out[c] rises on the same edge as gamma_start.
// - Elaboration: a failing check on the power-of-2 and PULSE_WIDTH range rules.
// STRUCTURE
// - Shared package temporal_pkg:
//     GAMMA_CYCLE_WIDTH / PULSE_WIDTH defaults
//     typedef phase_t (logic [VW-1:0])
//     typedef struct enc_vec_t {phase_t value[NUM_CHANNELS]; logic [NUM_CHANNELS-1:0] silent;}
// - Sub-module gamma_counter (aclk, grst -> phase, start, is_last), reused by other
//   temporal blocks.
// - Top level: the shadow/active registers, the handshake, and a per-channel pulse
//   compare generate loop.
// TESTING (G=16, PW=8, NUM_CHANNELS=4)
// 1. Reset, then vector {3,12,0,7}, silent=0000, accepted at phase 5. Next gamma:
//    ch0 high at phases 3..10; ch1 at 12..15 (clipped, 4 cycles); ch2 at 0..7;
//    ch3 at 7..14. All out bits are 0 during the accept gamma.
// 2. silent=0101 with values {2,2,2,2}: only ch1 and ch3 pulse, at phases 2..9.
// 3. Back-pressure: accept A at phase 2, then hold B valid. in_ready must be 0 at
//    phases 3..14 and 1 at phase 15. B is accepted at phase 15 and emitted one gamma
//    after A. No vector is lost or duplicated.
// 4. Direct load: shadow empty, vector transferred at phase 15 -> it emits in the
//    immediately following gamma cycle. The gamma after that is all-silent if no
//    vector was fed.
// 5. Reset mid-pulse: grst high for 1 cycle at phase 6, with ch0 pulsing and shadow
//    full. Next cycle: out=0, phase=0, gamma_start=1, in_ready=1. The shadow vector
//    is never emitted.
// 6. Sweep v from 0 to 15 on ch0 with PW=1 and PW=16 builds. Check the pulse start
//    phase equals v, and the length equals min(PW, 16-v).

Source files
------------

// File: rtl/temporal_pkg.sv
// Shared definitions for the temporal (race-logic) blocks: default gamma cycle
// geometry, the phase type and the encoder input vector layout.
package temporal_pkg;

    localparam int DEF_GAMMA_CYCLE_WIDTH = 16;
    localparam int DEF_PULSE_WIDTH       = 8;
    localparam int DEF_NUM_CHANNELS      = 4;
    localparam int DEF_VW                = $clog2(DEF_GAMMA_CYCLE_WIDTH);

    typedef logic [DEF_VW-1:0] phase_t;

    // One encoder vector: per-channel arrival time plus per-channel silence flag.
    typedef struct packed {
        phase_t [DEF_NUM_CHANNELS-1:0] value;
        logic   [DEF_NUM_CHANNELS-1:0] silent;
    } enc_vec_t;

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/gamma_counter.sv
// Free-running gamma cycle counter shared by the temporal blocks. Phase wraps
// LAST -> 0 every cycle with no stall; start is registered alongside phase.
module gamma_counter
    import temporal_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
    localparam int VW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst,
    output logic [VW-1:0] phase,
    output logic          start,
    output logic          is_last
);

    localparam logic [VW-1:0] LAST = VW'(GAMMA_CYCLE_WIDTH - 1);

    logic [VW-1:0] phase_nxt;

    assign is_last   = (phase == LAST);
    assign phase_nxt = is_last ? '0 : phase + VW'(1);

    // Advance the phase every cycle; start tracks phase == 0 on the same edge.
    always_ff @(posedge aclk) begin
        if (grst) begin
            phase <= '0;
            start <= 1'b1;
        end else begin
            phase <= phase_nxt;
            start <= (phase_nxt == '0);
        end
    end

endmodule

// File: rtl/temporal_encoder_b_t.sv
// Binary-to-temporal encoder. Vectors of arrival times are buffered through a
// one-entry shadow register into the active register at each gamma boundary,
// then each channel emits a pulse starting at its arrival phase, clipped at LAST.
module temporal_encoder_b_t
    import temporal_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
    parameter  int PULSE_WIDTH       = DEF_PULSE_WIDTH,
    parameter  int NUM_CHANNELS      = DEF_NUM_CHANNELS,
    localparam int VW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                       aclk,
    input  logic                       grst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CHANNELS*VW-1:0] in_values,
    input  logic [NUM_CHANNELS-1:0]    in_silent,
    output logic [VW-1:0]              gamma_phase,
    output logic                       gamma_start,
    output logic [NUM_CHANNELS-1:0]    out
);

    if (!is_pow2(GAMMA_CYCLE_WIDTH) || GAMMA_CYCLE_WIDTH < 2) begin : g_bad_gamma
        $error("GAMMA_CYCLE_WIDTH must be a power of 2 and at least 2");
    end
    if (PULSE_WIDTH < 1 || PULSE_WIDTH > GAMMA_CYCLE_WIDTH) begin : g_bad_pulse
        $error("PULSE_WIDTH must lie in 1..GAMMA_CYCLE_WIDTH");
    end

    localparam logic [VW:0] PW_EXT = (VW+1)'(PULSE_WIDTH);

    logic          is_last;
    logic [VW-1:0] phase;
    logic [VW-1:0] phase_nxt;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
    ) u_gamma_counter (
        .aclk   (aclk),
        .grst   (grst),
        .phase  (phase),
        .start  (gamma_start),
        .is_last(is_last)
    );

    assign gamma_phase = phase;
    assign phase_nxt   = is_last ? '0 : phase + VW'(1);

    logic                       shadow_full, shadow_full_nxt;
    logic [NUM_CHANNELS*VW-1:0] shadow_val,  shadow_val_nxt;
    logic [NUM_CHANNELS-1:0]    shadow_sil,  shadow_sil_nxt;
    logic [NUM_CHANNELS*VW-1:0] active_val,  active_val_nxt;
    logic [NUM_CHANNELS-1:0]    active_sil,  active_sil_nxt;
    logic [NUM_CHANNELS-1:0]    out_nxt;
    logic                       xfer;

    // Handshake: a vector transfers on a posedge where in_valid && in_ready.
    // in_ready is high whenever the shadow slot is free, and also at phase LAST
    // because the shadow drains into active on that same edge. The producer
    // holds in_values/in_silent stable while in_valid && !in_ready.
    assign in_ready = !shadow_full || is_last;
    assign xfer     = in_valid && in_ready;

    // Next-state of the shadow/active buffering around the gamma boundary.
    always_comb begin
        shadow_full_nxt = shadow_full;
        shadow_val_nxt  = shadow_val;
        shadow_sil_nxt  = shadow_sil;
        active_val_nxt  = active_val;
        active_sil_nxt  = active_sil;
        if (is_last) begin
            if (shadow_full) begin
                active_val_nxt = shadow_val;
                active_sil_nxt = shadow_sil;
                if (xfer) begin
                    shadow_val_nxt = in_values;
                    shadow_sil_nxt = in_silent;
                end else begin
                    shadow_full_nxt = 1'b0;
                end
            end else if (xfer) begin
                active_val_nxt = in_values;
                active_sil_nxt = in_silent;
            end else begin
                // Nothing queued: the next gamma cycle is quiet on every channel.
                active_sil_nxt = '1;
            end
        end else if (xfer) begin
            shadow_val_nxt  = in_values;
            shadow_sil_nxt  = in_silent;
            shadow_full_nxt = 1'b1;
        end
    end

    // Pulse compare against the phase and vector that will be live after this
    // edge, so out and gamma_phase change together. VW+1 bits keep v + PW from
    // wrapping, which is what clips pulses at LAST.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        logic [VW:0] ph_ext;
        logic [VW:0] v_ext;
        assign ph_ext     = {1'b0, phase_nxt};
        assign v_ext      = {1'b0, active_val_nxt[c*VW +: VW]};
        assign out_nxt[c] = !active_sil_nxt[c] && (ph_ext >= v_ext) && (ph_ext < v_ext + PW_EXT);
    end

    // Buffer and output registers; reset discards any held or pending vector.
    always_ff @(posedge aclk) begin
        if (grst) begin
            shadow_full <= 1'b0;
            shadow_val  <= '0;
            shadow_sil  <= '0;
            active_val  <= '0;
            active_sil  <= '1;
            out         <= '0;
        end else begin
            shadow_full <= shadow_full_nxt;
            shadow_val  <= shadow_val_nxt;
            shadow_sil  <= shadow_sil_nxt;
            active_val  <= active_val_nxt;
            active_sil  <= active_sil_nxt;
            out         <= out_nxt;
        end
    end

endmodule
